// File: rtl/voice_player.sv
// Multi-voice clip player: each frame walks the voices, reads the clip buffer, mixes and saturates.
// Define PLAYER_INTERP_EN for linear interpolation; otherwise each voice plays its nearest-lower sample.
module voice_player #(
  parameter int unsigned CLIP_LEN   = 64,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned INC_W      = 16,
  parameter int unsigned FRAME_LEN  = 256,
  localparam int unsigned ADDR_W    = $clog2(CLIP_LEN)
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic [NUM_VOICES-1:0]         trig,
  input  logic [NUM_VOICES-1:0]         loop_mode,
  input  logic [NUM_VOICES*INC_W-1:0]   phase_inc,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic signed [15:0]            mem_data,
  output logic signed [15:0]            mix_out,
  output logic                          mix_valid,
  output logic [NUM_VOICES-1:0]         active
);

  localparam int unsigned PH_W     = ADDR_W + FRAC_BITS;
  localparam int unsigned SUM_W    = ((PH_W > INC_W) ? PH_W : INC_W) + 1;
  localparam int unsigned CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned VID_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W    = 16 + $clog2(NUM_VOICES) + 1;
  localparam int unsigned PH_LIMIT = CLIP_LEN << FRAC_BITS;
`ifdef PLAYER_INTERP_EN
  localparam int unsigned PROD_W   = 17 + FRAC_BITS;
`endif

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_WAIT,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t                    state_q, state_d;
  logic [VID_W-1:0]          vidx_q, vidx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PH_W-1:0]           phase_q [NUM_VOICES];
  logic [PH_W-1:0]           phase_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]     active_q, active_d;
  logic [NUM_VOICES-1:0]     pending_q, pending_d;
  logic [NUM_VOICES-1:0]     loop_q, loop_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [15:0]        s0_q, s0_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic signed [15:0]        mix_out_q, mix_out_d;
  logic                      mix_valid_q, mix_valid_d;

  logic [PH_W-1:0]           cur_phase;
  logic [ADDR_W-1:0]         cur_idx;
  logic [INC_W-1:0]          cur_inc;
  logic [SUM_W-1:0]          sum;
  logic signed [16:0]        voice_val;
`ifdef PLAYER_INTERP_EN
  logic [FRAC_BITS-1:0]      cur_frac;
  logic [ADDR_W-1:0]         nxt_idx;
  logic signed [16:0]        diff;
  logic signed [PROD_W-1:0]  prod;
`endif

  // Datapath of the voice currently owned by the sequencer
  always_comb begin
    cur_phase = phase_q[vidx_q];
    cur_idx   = cur_phase[PH_W-1 -: ADDR_W];
    cur_inc   = phase_inc[vidx_q*INC_W +: INC_W];
    sum       = SUM_W'(cur_phase) + SUM_W'(cur_inc);
`ifdef PLAYER_INTERP_EN
    cur_frac  = cur_phase[FRAC_BITS-1:0];
    if (cur_idx == ADDR_W'(CLIP_LEN - 1)) begin
      nxt_idx = loop_q[vidx_q] ? '0 : cur_idx;
    end else begin
      nxt_idx = cur_idx + ADDR_W'(1);
    end
    // s0 arrives in WAIT, s1 is on mem_data during ACCUM
    diff      = 17'(mem_data) - 17'(s0_q);
    prod      = PROD_W'(diff) * $signed(PROD_W'(cur_frac));
    voice_val = 17'(s0_q) + 17'(prod >>> FRAC_BITS);
`else
    voice_val = 17'(s0_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    vidx_d      = vidx_q;
    cnt_d       = (cnt_q == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
    phase_d     = phase_q;
    active_d    = active_q;
    pending_d   = pending_q | trig;
    loop_d      = loop_q;
    acc_d       = acc_q;
    s0_d        = s0_q;
    mem_addr_d  = mem_addr_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d  = '0;
        vidx_d = '0;
        if (cnt_q == '0) begin
          // Frame start: latch modes and apply pending (or coincident) triggers
          loop_d = loop_mode;
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (pending_q[v] || trig[v]) begin
              phase_d[v]  = '0;
              active_d[v] = 1'b1;
            end
          end
          pending_d = '0;
          state_d   = S_FETCH0;
        end
      end
      S_FETCH0: begin
        mem_addr_d = cur_idx;
        state_d    = S_FETCH1;
      end
      S_FETCH1: begin
`ifdef PLAYER_INTERP_EN
        mem_addr_d = nxt_idx;
`else
        mem_addr_d = cur_idx;
`endif
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        s0_d    = mem_data;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (active_q[vidx_q]) begin
          acc_d = acc_q + ACC_W'(voice_val);
          if (loop_q[vidx_q]) begin
            phase_d[vidx_q] = PH_W'(sum % SUM_W'(PH_LIMIT));
          end else if (sum >= SUM_W'(PH_LIMIT)) begin
            active_d[vidx_q] = 1'b0;
          end else begin
            phase_d[vidx_q] = PH_W'(sum);
          end
        end
        if (vidx_q == VID_W'(NUM_VOICES - 1)) begin
          state_d = S_OUTPUT;
        end else begin
          vidx_d  = vidx_q + VID_W'(1);
          state_d = S_FETCH0;
        end
      end
      S_OUTPUT: begin
        if (acc_q > SAT_MAX) begin
          mix_out_d = 16'sh7FFF;
        end else if (acc_q < SAT_MIN) begin
          mix_out_d = 16'sh8000;
        end else begin
          mix_out_d = acc_q[15:0];
        end
        mix_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vidx_q      <= '0;
      cnt_q       <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      loop_q      <= '0;
      acc_q       <= '0;
      s0_q        <= '0;
      mem_addr_q  <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vidx_q      <= vidx_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      loop_q      <= loop_d;
      acc_q       <= acc_d;
      s0_q        <= s0_d;
      mem_addr_q  <= mem_addr_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_voice_player.sv
// Directed bench for voice_player; expected values follow PLAYER_INTERP_EN when defined.
module tb_voice_player;

  localparam int unsigned CLIP_LEN   = 64;
  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned INC_W      = 16;
  localparam int unsigned FRAME_LEN  = 256;
  localparam int unsigned ADDR_W     = $clog2(CLIP_LEN);

  logic                        mclk = 1'b0;
  logic                        rst;
  logic [NUM_VOICES-1:0]       trig;
  logic [NUM_VOICES-1:0]       loop_mode;
  logic [NUM_VOICES*INC_W-1:0] phase_inc;
  logic [ADDR_W-1:0]           mem_addr;
  logic signed [15:0]          mem_data;
  logic signed [15:0]          mix_out;
  logic                        mix_valid;
  logic [NUM_VOICES-1:0]       active;

  logic signed [15:0]          mem [CLIP_LEN];
  int                          n_tests = 0;
  int                          n_fail  = 0;

  voice_player #(
    .CLIP_LEN  (CLIP_LEN),
    .NUM_VOICES(NUM_VOICES),
    .FRAC_BITS (FRAC_BITS),
    .INC_W     (INC_W),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .trig     (trig),
    .loop_mode(loop_mode),
    .phase_inc(phase_inc),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mix_out  (mix_out),
    .mix_valid(mix_valid),
    .active   (active)
  );

  always #5 mclk = ~mclk;

  // Clip buffer with one cycle read latency
  always @(posedge mclk) mem_data <= mem[mem_addr];

  task automatic fill_ramp();
    for (int i = 0; i < int'(CLIP_LEN); i++) mem[i] = 16'(i * 100);
  endtask

  task automatic fill_const(input logic signed [15:0] val);
    for (int i = 0; i < int'(CLIP_LEN); i++) mem[i] = val;
  endtask

  // Reset, then trigger on the count-0 cycle right after release
  task automatic start(input logic [NUM_VOICES-1:0] mask, input logic [NUM_VOICES-1:0] lm,
                       input logic [NUM_VOICES*INC_W-1:0] inc);
    @(negedge mclk);
    rst = 1'b1;
    trig = '0;
    loop_mode = lm;
    phase_inc = inc;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    trig = mask;
    @(negedge mclk);
    trig = '0;
  endtask

  task automatic wait_mix(output logic got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge mclk);
      if (mix_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    trig = '0;
    loop_mode = '0;
    phase_inc = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge mclk);
    n_tests++;
    if (mix_out !== 16'sd0 || mix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mix: mix_out=%0d mix_valid=%0b expected 0 0", mix_out, mix_valid);
    end
    n_tests++;
    if (active !== '0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: active=%b mem_addr=%0d expected 0 0", active, mem_addr);
    end
  endtask

  task automatic test_loop_wrap();
    logic got;
    logic signed [15:0] exp_v;
    fill_ramp();
    start(4'b0001, 4'b1111, 64'h0000_0000_0000_0100);
    for (int k = 0; k < 66; k++) begin
      wait_mix(got);
      exp_v = 16'((k % 64) * 100);
      n_tests++;
      if (got !== 1'b1 || mix_out !== exp_v) begin
        n_fail++;
        $display("FAIL loop_wrap frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, exp_v);
      end
    end
    n_tests++;
    if (active !== 4'b0001) begin
      n_fail++;
      $display("FAIL loop_active: active=%b expected 0001", active);
    end
  endtask

  task automatic test_frac_step();
    logic got;
    logic signed [15:0] exp_v;
    fill_ramp();
    start(4'b0001, 4'b1111, 64'h0000_0000_0000_0080);
    for (int k = 0; k < 6; k++) begin
      wait_mix(got);
`ifdef PLAYER_INTERP_EN
      exp_v = 16'(k * 50);
`else
      exp_v = 16'((k / 2) * 100);
`endif
      n_tests++;
      if (got !== 1'b1 || mix_out !== exp_v) begin
        n_fail++;
        $display("FAIL frac_step frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, exp_v);
      end
    end
  endtask

  // Phase 0x3F80 sits at idx 63, frac 0x80, so the loop neighbour is buf[0]
  task automatic test_loop_edge();
    logic got;
    int exp_tab [4];
`ifdef PLAYER_INTERP_EN
    exp_tab = '{0, 3150, 6300, 6250};
`else
    exp_tab = '{0, 6300, 6300, 6200};
`endif
    fill_ramp();
    start(4'b0001, 4'b1111, 64'h0000_0000_0000_3F80);
    for (int k = 0; k < 4; k++) begin
      wait_mix(got);
      n_tests++;
      if (got !== 1'b1 || mix_out !== 16'(exp_tab[k])) begin
        n_fail++;
        $display("FAIL loop_edge frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, exp_tab[k]);
      end
    end
  endtask

  task automatic test_oneshot_end();
    logic got;
    int exp_tab [3];
    fill_ramp();
    start(4'b0001, 4'b0000, 64'h0000_0000_0000_0100);
    for (int k = 0; k < 64; k++) begin
      wait_mix(got);
      n_tests++;
      if (got !== 1'b1 || mix_out !== 16'(k * 100)) begin
        n_fail++;
        $display("FAIL oneshot frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, k * 100);
      end
    end
    n_tests++;
    if (active !== 4'b0000) begin
      n_fail++;
      $display("FAIL oneshot_active: active=%b expected 0000", active);
    end
    wait_mix(got);
    n_tests++;
    if (got !== 1'b1 || mix_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL oneshot_after: mix_out=%0d seen=%0b expected 0", mix_out, got);
    end
    // At idx 63 the one-shot neighbour is idx 63 itself
    exp_tab = '{0, 6300, 0};
    start(4'b0001, 4'b0000, 64'h0000_0000_0000_3F80);
    for (int k = 0; k < 3; k++) begin
      wait_mix(got);
      n_tests++;
      if (got !== 1'b1 || mix_out !== 16'(exp_tab[k])) begin
        n_fail++;
        $display("FAIL oneshot_edge frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, exp_tab[k]);
      end
    end
  endtask

  task automatic test_hold_restart();
    logic got;
    int exp_tab [8];
    exp_tab = '{0, 100, 200, 300, 300, 300, 0, 100};
    fill_ramp();
    start(4'b0001, 4'b1111, 64'h0000_0000_0000_0100);
    for (int k = 0; k < 8; k++) begin
      wait_mix(got);
      n_tests++;
      if (got !== 1'b1 || mix_out !== 16'(exp_tab[k])) begin
        n_fail++;
        $display("FAIL hold_restart frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, exp_tab[k]);
      end
      if (k == 2) phase_inc = '0;
      if (k == 5) begin
        phase_inc = 64'h0000_0000_0000_0100;
        trig = 4'b0001;
        @(negedge mclk);
        trig = '0;
      end
    end
    n_tests++;
    if (active !== 4'b0001) begin
      n_fail++;
      $display("FAIL restart_active: active=%b expected 0001", active);
    end
  endtask

  task automatic test_multi_voice();
    logic got;
    fill_ramp();
    start(4'b1111, 4'b1111, 64'h0400_0300_0200_0100);
    for (int k = 0; k < 4; k++) begin
      wait_mix(got);
      n_tests++;
      if (got !== 1'b1 || mix_out !== 16'(k * 1000)) begin
        n_fail++;
        $display("FAIL multi_voice frame %0d: mix_out=%0d seen=%0b expected %0d", k, mix_out, got, k * 1000);
      end
    end
  endtask

  task automatic test_saturation();
    logic got;
    fill_const(16'sd30000);
    start(4'b1111, 4'b1111, 64'h0100_0100_0100_0100);
    wait_mix(got);
    n_tests++;
    if (got !== 1'b1 || mix_out !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_pos: mix_out=%0d seen=%0b expected 32767", mix_out, got);
    end
    fill_const(-16'sd30000);
    start(4'b1111, 4'b1111, 64'h0100_0100_0100_0100);
    wait_mix(got);
    n_tests++;
    if (got !== 1'b1 || mix_out !== -16'sd32768) begin
      n_fail++;
      $display("FAIL sat_neg: mix_out=%0d seen=%0b expected -32768", mix_out, got);
    end
  endtask

  task automatic test_reset_midframe();
    logic got;
    logic early;
    fill_ramp();
    start(4'b1111, 4'b1111, 64'h0100_0100_0100_0100);
    wait_mix(got);
    // mix_valid is seen at count 18; 243 more cycles lands on count 5
    repeat (FRAME_LEN - 18 + 5) @(negedge mclk);
    n_tests++;
    if (active !== 4'b1111) begin
      n_fail++;
      $display("FAIL midframe_pre: active=%b expected 1111", active);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (active !== '0 || mix_out !== 16'sd0 || mix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_rst: active=%b mix_out=%0d mix_valid=%0b expected 0 0 0", active, mix_out, mix_valid);
    end
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    early = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(negedge mclk);
      if (mix_valid !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_early: mix_valid seen=%0b expected 0", early);
    end
    @(negedge mclk);
    n_tests++;
    if (mix_valid !== 1'b1 || mix_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL midframe_first: mix_valid=%0b mix_out=%0d expected 1 0", mix_valid, mix_out);
    end
  endtask

  initial begin
    test_reset();
    test_loop_wrap();
    test_frac_step();
    test_loop_edge();
    test_oneshot_end();
    test_hold_restart();
    test_multi_voice();
    test_saturation();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_player.md
VOICE_PLAYER -- requirements
Module: voice_player

Interface
REQ-001 Parameter CLIP_LEN, 64, clip depth in samples; ADDR_W = $clog2(CLIP_LEN).
REQ-002 Parameter NUM_VOICES, 4, number of independent voices.
REQ-003 Parameter FRAC_BITS, 8, fractional phase bits.
REQ-004 Parameter INC_W, 16, per-voice phase increment width.
REQ-005 Parameter FRAME_LEN, 256, mclk cycles per output sample; NUM_VOICES*4+2 <= FRAME_LEN.
REQ-006 mclk  in  1  master clock (256x sample rate); the only clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 trig  in  NUM_VOICES  per-voice start/restart pulse.
REQ-009 loop_mode  in  NUM_VOICES  1 = loop, 0 = one-shot; sampled at the start of each frame.
REQ-010 phase_inc  in  NUM_VOICES*INC_W  packed unsigned increments, voice v at [v*INC_W +: INC_W].
REQ-011 mem_addr  out  ADDR_W  clip buffer read address.
REQ-012 mem_data  in  16  signed buffer data, valid one cycle after mem_addr.
REQ-013 mix_out  out  16  signed saturated mix.
REQ-014 mix_valid  out  1  one-cycle strobe per frame when mix_out updates.
REQ-015 active  out  NUM_VOICES  voice-playing flags.

Function
REQ-016 The frame counter SHALL count 0..FRAME_LEN-1 and wrap; the sequencer SHALL start at count 0.
REQ-017 Sequencer states SHALL be IDLE -> per voice (FETCH0, FETCH1, WAIT, ACCUM) -> OUTPUT -> IDLE, with voices processed 0..NUM_VOICES-1.
REQ-018 Each voice SHALL hold a phase of ADDR_W+FRAC_BITS bits: idx = phase[top ADDR_W], frac = phase[FRAC_BITS-1:0].
REQ-019 FETCH0 SHALL read s0 = buf[idx].
REQ-020 FETCH1 SHALL read s1 = buf[nxt]:
- loop mode: nxt = (idx+1) mod CLIP_LEN.
- one-shot mode at idx = CLIP_LEN-1: nxt = idx.
REQ-021 Voice value SHALL be s0 + (((s1-s0)*frac) >>> FRAC_BITS), computed at 17+FRAC_BITS bits signed.
REQ-022 Inactive voices SHALL contribute 0 and SHALL NOT change their phase.
REQ-023 After use, an active voice SHALL advance phase by phase_inc:
- loop mode: wrap modulo CLIP_LEN<<FRAC_BITS.
- one-shot mode: if the sum >= CLIP_LEN<<FRAC_BITS, clear active and hold the phase.
REQ-024 The accumulator SHALL be 16+$clog2(NUM_VOICES)+1 bits signed, cleared in IDLE.
REQ-025 In OUTPUT, mix_out SHALL be updated with the accumulator saturated to [-32768, 32767].
REQ-026 mix_valid SHALL pulse for one cycle at frame count NUM_VOICES*4+1; mix_out SHALL hold between pulses.
REQ-027 A trig bit SHALL set a pending flag on any cycle; pending flags SHALL be applied at frame count 0 (phase = 0, active = 1) and then cleared.
REQ-028 trig on an already-active voice SHALL restart it at the next frame.
REQ-029 trig coincident with count 0 SHALL apply in that frame.
REQ-030 phase_inc = 0 on an active voice SHALL hold that voice's sample indefinitely.

Reset
REQ-031 While rst is high, the following SHALL be 0: mix_out, mix_valid, active, mem_addr, all phases, pending flags, accumulator and frame counter, with the sequencer in IDLE.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no mix_valid.
REQ-033 The first mix_valid after rst deasserts SHALL occur NUM_VOICES*4+1 cycles after the first mclk edge.

Configuration
REQ-034 With PLAYER_INTERP_EN defined, linear interpolation per REQ-020..021 SHALL be used.
REQ-035 Without PLAYER_INTERP_EN, voice value SHALL equal s0 (nearest-lower).
- FETCH1 SHALL still occupy its cycle, so that frame timing is unchanged.
- mem_addr SHALL hold idx during FETCH1.

Verification
REQ-036 Bench setup: CLIP_LEN=64, NUM_VOICES=4, FRAC_BITS=8, FRAME_LEN=256, buf[i]=i*100.
REQ-037 Scenario: trig[0], loop, inc=0x100 -> mix_out frames 0,100,...,6300,0,100 (wraps); active[0] stays 1.
REQ-038 Scenario: trig[0], inc=0x080 -> mix_out 0,50,100,150,...; with PLAYER_INTERP_EN undefined -> 0,0,100,100,....
REQ-039 Scenario: loop, inc=0x080, frame with phase at idx=63 and frac=0x80 -> mix_out (6300+0)/2 = 3150.
REQ-040 Scenario: one-shot, inc=0x100 -> last nonzero mix_out 6300 at frame 63, then active[0]=0 and mix_out=0.
REQ-041 Scenario: buffer filled with 30000, four voices triggered -> mix_out=32767; buffer filled with -30000 -> mix_out=-32768.
REQ-042 Scenario: rst pulsed at frame count 5 with all voices active -> active=0, mix_out=0, no mix_valid until 17 cycles after release.
